// File: rtl/stream_demux_1to2.sv
// ---------------------------------------------------------------------------
// stream_demux_1to2
//   Packet-aware 1-to-2 stream demultiplexer. The channel is chosen from s_sel
//   on the first beat of a packet and is held until the beat carrying s_last.
//   Each output channel has a one-entry registered stage. Per-channel counters
//   record how many complete packets were accepted into each channel.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/
//   s_last/s_sel               upstream stream and channel select
//   m0_valid/m0_ready/
//   m0_data/m0_last            channel 0 downstream stream
//   m1_valid/m1_ready/
//   m1_data/m1_last            channel 1 downstream stream
//   pkt_cnt0, pkt_cnt1         wrap-around completed-packet counters
//   busy                       a packet is in progress
// ---------------------------------------------------------------------------
module stream_demux_1to2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_sel,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_last,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_last,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   target;
  logic   slot_free0, slot_free1;
  logic   accept, load0, load1;

  // A slot can take a new beat when it is empty or being drained this cycle,
  // so a pop and a load may coincide for full throughput.
  assign slot_free0 = !m0_valid || m0_ready;
  assign slot_free1 = !m1_valid || m1_ready;

  // Target is live from s_sel only between packets; mid-packet it is locked.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    target    = s_sel;
    state_nxt = state;
    unique case (state)
      ROUTE0:  target = 1'b0;
      ROUTE1:  target = 1'b1;
      default: target = s_sel;
    endcase
    if (accept) begin
      if (s_last)      state_nxt = IDLE;
      else if (state == IDLE)
        state_nxt = s_sel ? ROUTE1 : ROUTE0;
    end
  end

  // s_ready depends only on the target slot, never on s_valid.
  assign s_ready = target ? slot_free1 : slot_free0;
  assign accept  = s_valid && s_ready;
  assign load0   = accept && !target;
  assign load1   = accept &&  target;
  assign busy    = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Output stages. Data/last are cleared on reset too, so a discarded
  // partial packet leaves nothing visible on the outputs.
  // NOTE: data registers are reset here because the interface promises
  // zeroed outputs after reset; pure datapath storage would not need it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_valid <= 1'b0;
      m0_data  <= '0;
      m0_last  <= 1'b0;
    end else if (load0) begin
      m0_valid <= 1'b1;
      m0_data  <= s_data;
      m0_last  <= s_last;
    end else if (m0_ready) begin
      m0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_valid <= 1'b0;
      m1_data  <= '0;
      m1_last  <= 1'b0;
    end else if (load1) begin
      m1_valid <= 1'b1;
      m1_data  <= s_data;
      m1_last  <= s_last;
    end else if (m1_ready) begin
      m1_valid <= 1'b0;
    end
  end

  // Counters count packets accepted into the stage (on the s_last beat),
  // not packets delivered downstream; they wrap with no saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (load0 && s_last) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (load1 && s_last) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux_1to2.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1to2
//   Directed bench for stream_demux_1to2. A second instance with CNT_W=2
//   shares the stimulus and is used to observe counter wrap-around.
// ---------------------------------------------------------------------------
module tb_stream_demux_1to2;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_sel = 1'b0;
  logic          m0_valid, m0_last, m1_valid, m1_last;
  logic          m0_ready = 1'b1;
  logic          m1_ready = 1'b1;
  logic [DW-1:0] m0_data, m1_data;
  logic [7:0]    pkt_cnt0, pkt_cnt1;
  logic          busy;

  logic          w_s_ready, w_m0_valid, w_m0_last, w_m1_valid, w_m1_last, w_busy;
  logic [DW-1:0] w_m0_data, w_m1_data;
  logic [1:0]    w_pkt_cnt0, w_pkt_cnt1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_demux_1to2 #(.DATA_W(DW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_sel(s_sel),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data), .m0_last(m0_last),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data), .m1_last(m1_last),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
  );

  stream_demux_1to2 #(.DATA_W(DW), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(w_s_ready), .s_data(s_data), .s_last(s_last), .s_sel(s_sel),
    .m0_valid(w_m0_valid), .m0_ready(m0_ready), .m0_data(w_m0_data), .m0_last(w_m0_last),
    .m1_valid(w_m1_valid), .m1_ready(m1_ready), .m1_data(w_m1_data), .m1_last(w_m1_last),
    .pkt_cnt0(w_pkt_cnt0), .pkt_cnt1(w_pkt_cnt1), .busy(w_busy)
  );

  // Advance one clock; inputs are driven and outputs sampled 2 time units
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    s_valid = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, input logic sel);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    s_sel   = sel;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last, pkt_cnt0, pkt_cnt1, busy} !== '0) begin
      failures++;
      $display("FAIL reset_state: m0v=%b m0d=%h m0l=%b m1v=%b m1d=%h m1l=%b c0=%0d c1=%0d busy=%b, required all 0",
               m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last, pkt_cnt0, pkt_cnt1, busy);
    end
    apply_reset();
  endtask

  // 3-beat packet to ch1; sel flips mid-packet and must be ignored.
  task automatic test_three_beat_ch1();
    logic [DW-1:0] d [3];
    d[0] = 8'hA1; d[1] = 8'hA2; d[2] = 8'hA3;
    for (int i = 0; i < 3; i++) begin
      send(d[i], (i == 2), (i == 0) ? 1'b1 : 1'b0);
      step();
      checks++;
      if ({m1_valid, m1_data, m1_last, m0_valid, busy} !== {1'b1, d[i], (i == 2), 1'b0, (i != 2)}) begin
        failures++;
        $display("FAIL ch1_beat%0d: m1v=%b m1d=%h m1l=%b m0v=%b busy=%b, required 1 %h %b 0 %b",
                 i, m1_valid, m1_data, m1_last, m0_valid, busy, d[i], (i == 2), (i != 2));
      end
    end
    s_valid = 1'b0;
    step();
    checks++;
    if ({m1_valid, m0_valid, pkt_cnt1, pkt_cnt0} !== {1'b0, 1'b0, 8'd1, 8'd0}) begin
      failures++;
      $display("FAIL ch1_done: m1v=%b m0v=%b c1=%0d c0=%0d, required 0 0 1 0",
               m1_valid, m0_valid, pkt_cnt1, pkt_cnt0);
    end
  endtask

  task automatic test_sel_locked();
    send(8'hB1, 1'b0, 1'b0);
    step();
    checks++;
    if ({m0_valid, m0_data, m0_last, m1_valid, busy} !== {1'b1, 8'hB1, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL lock_beat1: m0v=%b m0d=%h m0l=%b m1v=%b busy=%b, required 1 b1 0 0 1",
               m0_valid, m0_data, m0_last, m1_valid, busy);
    end
    send(8'hB2, 1'b1, 1'b1);
    step();
    checks++;
    if ({m0_valid, m0_data, m0_last, m1_valid, pkt_cnt0, pkt_cnt1, busy} !==
        {1'b1, 8'hB2, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL lock_beat2: m0v=%b m0d=%h m0l=%b m1v=%b c0=%0d c1=%0d busy=%b, required 1 b2 1 0 1 1 0",
               m0_valid, m0_data, m0_last, m1_valid, pkt_cnt0, pkt_cnt1, busy);
    end
    s_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    m0_ready = 1'b0;
    send(8'hC1, 1'b0, 1'b0);
    step();
    send(8'hC2, 1'b0, 1'b0);
    #1;
    checks++;
    if ({s_ready, m0_valid, m0_data} !== {1'b0, 1'b1, 8'hC1}) begin
      failures++;
      $display("FAIL bp_stall: s_ready=%b m0v=%b m0d=%h, required 0 1 c1", s_ready, m0_valid, m0_data);
    end
    step();
    checks++;
    if ({s_ready, m0_valid, m0_data, m0_last} !== {1'b0, 1'b1, 8'hC1, 1'b0}) begin
      failures++;
      $display("FAIL bp_hold: s_ready=%b m0v=%b m0d=%h m0l=%b, required 0 1 c1 0",
               s_ready, m0_valid, m0_data, m0_last);
    end
    m0_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: s_ready=%b, required 1", s_ready);
    end
    step();
    checks++;
    if ({m0_valid, m0_data} !== {1'b1, 8'hC2}) begin
      failures++;
      $display("FAIL bp_resume: m0v=%b m0d=%h, required 1 c2", m0_valid, m0_data);
    end
    send(8'hC3, 1'b1, 1'b0);
    step();
    checks++;
    if ({m0_valid, m0_data, m0_last, pkt_cnt0} !== {1'b1, 8'hC3, 1'b1, 8'd2}) begin
      failures++;
      $display("FAIL bp_last: m0v=%b m0d=%h m0l=%b c0=%0d, required 1 c3 1 2",
               m0_valid, m0_data, m0_last, pkt_cnt0);
    end
    s_valid = 1'b0;
    step();
    checks++;
    if (m0_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: m0v=%b, required 0", m0_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d [4];
    d[0] = 8'hD0; d[1] = 8'hD1; d[2] = 8'hD2; d[3] = 8'hD3;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send(d[i], 1'b1, i[0]);
      step();
      checks++;
      if (i[0] == 1'b0 &&
          {m0_valid, m0_data, m0_last, m1_valid, busy} !== {1'b1, d[i], 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL b2b_%0d: m0v=%b m0d=%h m0l=%b m1v=%b busy=%b, required 1 %h 1 0 0",
                 i, m0_valid, m0_data, m0_last, m1_valid, busy, d[i]);
      end else if (i[0] == 1'b1 &&
          {m1_valid, m1_data, m1_last, m0_valid, busy} !== {1'b1, d[i], 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL b2b_%0d: m1v=%b m1d=%h m1l=%b m0v=%b busy=%b, required 1 %h 1 0 0",
                 i, m1_valid, m1_data, m1_last, m0_valid, busy, d[i]);
      end
    end
    s_valid = 1'b0;
    step();
    checks++;
    if ({pkt_cnt0, pkt_cnt1} !== {8'd2, 8'd2}) begin
      failures++;
      $display("FAIL b2b_counts: c0=%0d c1=%0d, required 2 2", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_reset_mid_packet();
    send(8'hE1, 1'b0, 1'b1);
    step();
    send(8'hE2, 1'b0, 1'b1);
    checks++;
    if ({m1_valid, m1_data, busy} !== {1'b1, 8'hE1, 1'b1}) begin
      failures++;
      $display("FAIL midrst_pre: m1v=%b m1d=%h busy=%b, required 1 e1 1", m1_valid, m1_data, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({m0_valid, m1_valid, pkt_cnt0, pkt_cnt1, busy} !== '0) begin
      failures++;
      $display("FAIL midrst_clear: m0v=%b m1v=%b c0=%0d c1=%0d busy=%b, required all 0",
               m0_valid, m1_valid, pkt_cnt0, pkt_cnt1, busy);
    end
    s_valid = 1'b0;
    #3 rst_n = 1'b1;
    step();
    send(8'hF1, 1'b1, 1'b0);
    step();
    checks++;
    if ({m0_valid, m0_data, m0_last, m1_valid, pkt_cnt0, pkt_cnt1, busy} !==
        {1'b1, 8'hF1, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_next: m0v=%b m0d=%h m0l=%b m1v=%b c0=%0d c1=%0d busy=%b, required 1 f1 1 0 1 0 0",
               m0_valid, m0_data, m0_last, m1_valid, pkt_cnt0, pkt_cnt1, busy);
    end
    s_valid = 1'b0;
    step();
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp_w [5];
    exp_w[0] = 2'd1; exp_w[1] = 2'd2; exp_w[2] = 2'd3; exp_w[3] = 2'd0; exp_w[4] = 2'd1;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'h60 + 8'(i), 1'b1, 1'b1);
      step();
      checks++;
      if ({w_pkt_cnt1, pkt_cnt1} !== {exp_w[i], 8'(i + 1)}) begin
        failures++;
        $display("FAIL wrap_%0d: cnt1(w=2)=%0d cnt1(w=8)=%0d, required %0d %0d",
                 i, w_pkt_cnt1, pkt_cnt1, exp_w[i], i + 1);
      end
    end
    s_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_three_beat_ch1();
    test_sel_locked();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
